// File: rtl/hit_judge_if.sv
// Bundle between the note sequencer / player buttons and the hit judge,
// plus the graded results that feed the score counter.
interface hit_judge_if;
    logic [1:0] game_state;
    logic [1:0] btn_raw;
    logic       note_arrive;
    logic [1:0] note_lane;
    logic [1:0] hit;
    logic       hit_valid;
    logic [7:0] combo;
    logic [7:0] max_combo;
    logic       miss_pulse;

    modport master (
        output game_state, btn_raw, note_arrive, note_lane,
        input  hit, hit_valid, combo, max_combo, miss_pulse
    );

    modport slave (
        input  game_state, btn_raw, note_arrive, note_lane,
        output hit, hit_valid, combo, max_combo, miss_pulse
    );
endinterface

// File: rtl/hit_judge.sv
// Hit judge: synchronises the lane buttons, opens a timing window on each
// note arrival and grades it into a per-lane hit mask and a running combo.
module hit_judge #(
    parameter int WINDOW_CYCLES = 2500000,
    parameter int CNT_W         = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    hit_judge_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [1:0]       sync1_q, sync2_q, prev_q;
    logic             open_q, open_d;
    logic [1:0]       pending_q, pending_d;
    logic [1:0]       got_q, got_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       hit_q, hit_d;
    logic             hit_valid_q, hit_valid_d;
    logic             miss_q, miss_d;
    logic [7:0]       combo_q, combo_d;
    logic [7:0]       max_q, max_d;

    logic [1:0]       press;
    logic             in_play, clear_scores, arrive, close;
    logic [1:0]       grade;

    // Two-flop synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Window bookkeeping and grading; leaving play always discards the window silently.
    always_comb begin
        press        = sync2_q & ~prev_q;
        in_play      = (bus.game_state == ST_PLAY);
        clear_scores = (bus.game_state == ST_IDLE) || (bus.game_state == ST_SELECT);
        arrive       = in_play && bus.note_arrive && (bus.note_lane != 2'b00);
        open_d       = open_q;
        pending_d    = pending_q;
        got_d        = got_q;
        cnt_d        = cnt_q;
        hit_d        = 2'b00;
        hit_valid_d  = 1'b0;
        miss_d       = 1'b0;
        combo_d      = combo_q;
        close        = 1'b0;
        grade        = 2'b00;

        if (!in_play) begin
            open_d    = 1'b0;
            pending_d = 2'b00;
            got_d     = 2'b00;
            cnt_d     = '0;
            if (clear_scores) begin
                combo_d = 8'd0;
            end
        end else begin
            if (open_q) begin
                if (arrive) begin
                    // Preempted: presses this cycle belong to the new window only.
                    close = 1'b1;
                    grade = got_q;
                end else if (cnt_q == '0) begin
                    close  = 1'b1;
                    grade  = got_q | (press & pending_q);
                    open_d = 1'b0;
                end else begin
                    got_d = got_q | (press & pending_q);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            if (close) begin
                hit_d       = grade;
                hit_valid_d = 1'b1;
                if (grade == pending_q) begin
                    combo_d = sat_inc(combo_q);
                end else begin
                    combo_d = 8'd0;
                    miss_d  = 1'b1;
                end
            end
            if (arrive) begin
                open_d    = 1'b1;
                pending_d = bus.note_lane;
                got_d     = press & bus.note_lane;
                cnt_d     = CNT_LOAD;
            end
        end

        max_d = clear_scores ? 8'd0 : max8(max_q, combo_d);
    end

    // Window and score registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q      <= 1'b0;
            pending_q   <= 2'b00;
            got_q       <= 2'b00;
            cnt_q       <= '0;
            hit_q       <= 2'b00;
            hit_valid_q <= 1'b0;
            miss_q      <= 1'b0;
            combo_q     <= 8'd0;
            max_q       <= 8'd0;
        end else begin
            open_q      <= open_d;
            pending_q   <= pending_d;
            got_q       <= got_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            hit_valid_q <= hit_valid_d;
            miss_q      <= miss_d;
            combo_q     <= combo_d;
            max_q       <= max_d;
        end
    end

    assign bus.hit        = hit_q;
    assign bus.hit_valid  = hit_valid_q;
    assign bus.miss_pulse = miss_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_q;
endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with an 8-cycle window.
module tb_hit_judge;
    localparam int WIN = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hit_judge_if bus ();

    hit_judge #(.WINDOW_CYCLES(WIN), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One note: arrival edge E, optional press mask raised after E+d and
    // dropped after E+d+2. Returns just after edge E+7 (one before close).
    task automatic run_note(input logic [1:0] lane, input logic [1:0] pmask, input int d);
        @(negedge clk);
        bus.note_arrive = 1'b1;
        bus.note_lane   = lane;
        @(negedge clk);
        bus.note_arrive = 1'b0;
        bus.note_lane   = 2'b00;
        for (int k = 1; k <= WIN - 1; k++) begin
            @(negedge clk);
            if (k == d)     bus.btn_raw = bus.btn_raw | pmask;
            if (k == d + 2) bus.btn_raw = bus.btn_raw & ~pmask;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (bus.hit !== 2'b00) begin n_err++; $display("FAIL rst_hit: got %0h expected 0", bus.hit); end
        n_vec++; if (bus.hit_valid !== 1'b0) begin n_err++; $display("FAIL rst_hv: got %0h expected 0", bus.hit_valid); end
        n_vec++; if (bus.combo !== 8'd0) begin n_err++; $display("FAIL rst_combo: got %0d expected 0", bus.combo); end
        n_vec++; if (bus.max_combo !== 8'd0) begin n_err++; $display("FAIL rst_max: got %0d expected 0", bus.max_combo); end
        n_vec++; if (bus.miss_pulse !== 1'b0) begin n_err++; $display("FAIL rst_miss: got %0h expected 0", bus.miss_pulse); end
    endtask

    task automatic test_single_hit();
        rst_n          = 1'b1;
        bus.game_state = 2'd2;
        repeat (2) @(negedge clk);
        run_note(2'b01, 2'b01, 3);
        n_vec++; if (bus.hit_valid !== 1'b0) begin n_err++; $display("FAIL single_early_hv: got %0h expected 0", bus.hit_valid); end
        @(negedge clk);
        n_vec++; if (bus.hit !== 2'b01) begin n_err++; $display("FAIL single_hit: got %0h expected 1", bus.hit); end
        n_vec++; if (bus.hit_valid !== 1'b1) begin n_err++; $display("FAIL single_hv: got %0h expected 1", bus.hit_valid); end
        n_vec++; if (bus.combo !== 8'd1) begin n_err++; $display("FAIL single_combo: got %0d expected 1", bus.combo); end
        n_vec++; if (bus.miss_pulse !== 1'b0) begin n_err++; $display("FAIL single_miss: got %0h expected 0", bus.miss_pulse); end
        n_vec++; if (bus.max_combo !== 8'd1) begin n_err++; $display("FAIL single_max: got %0d expected 1", bus.max_combo); end
        @(negedge clk);
        n_vec++; if (bus.hit_valid !== 1'b0) begin n_err++; $display("FAIL single_hv_drop: got %0h expected 0", bus.hit_valid); end
        n_vec++; if (bus.hit !== 2'b00) begin n_err++; $display("FAIL single_hit_drop: got %0h expected 0", bus.hit); end
    endtask

    task automatic test_reset_midwindow();
        bit seen;
        @(negedge clk);
        bus.note_arrive = 1'b1;
        bus.note_lane   = 2'b01;
        @(negedge clk);
        bus.note_arrive = 1'b0;
        bus.note_lane   = 2'b00;
        bus.btn_raw     = 2'b01;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.combo !== 8'd0) begin n_err++; $display("FAIL midrst_combo: got %0d expected 0", bus.combo); end
        n_vec++; if (bus.max_combo !== 8'd0) begin n_err++; $display("FAIL midrst_max: got %0d expected 0", bus.max_combo); end
        @(negedge clk);
        rst_n       = 1'b1;
        bus.btn_raw = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.hit_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_pulse: got %0h expected 0", seen); end
    endtask

    task automatic test_partial();
        run_note(2'b01, 2'b01, 2);
        @(negedge clk);
        n_vec++; if (bus.combo !== 8'd1) begin n_err++; $display("FAIL partial_pre_combo: got %0d expected 1", bus.combo); end
        run_note(2'b11, 2'b10, 2);
        @(negedge clk);
        n_vec++; if (bus.hit !== 2'b10) begin n_err++; $display("FAIL partial_hit: got %0h expected 2", bus.hit); end
        n_vec++; if (bus.hit_valid !== 1'b1) begin n_err++; $display("FAIL partial_hv: got %0h expected 1", bus.hit_valid); end
        n_vec++; if (bus.combo !== 8'd0) begin n_err++; $display("FAIL partial_combo: got %0d expected 0", bus.combo); end
        n_vec++; if (bus.miss_pulse !== 1'b1) begin n_err++; $display("FAIL partial_miss: got %0h expected 1", bus.miss_pulse); end
        n_vec++; if (bus.max_combo !== 8'd1) begin n_err++; $display("FAIL partial_max: got %0d expected 1", bus.max_combo); end
    endtask

    task automatic test_close_edge_press();
        // Press lands exactly on the closing edge and still counts.
        run_note(2'b10, 2'b10, 5);
        @(negedge clk);
        n_vec++; if (bus.hit !== 2'b10) begin n_err++; $display("FAIL edge_hit: got %0h expected 2", bus.hit); end
        n_vec++; if (bus.combo !== 8'd1) begin n_err++; $display("FAIL edge_combo: got %0d expected 1", bus.combo); end
        n_vec++; if (bus.miss_pulse !== 1'b0) begin n_err++; $display("FAIL edge_miss: got %0h expected 0", bus.miss_pulse); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_held_button();
        // A button already held before the window gives no fresh press.
        bus.btn_raw = 2'b01;
        repeat (4) @(negedge clk);
        run_note(2'b01, 2'b00, 1);
        @(negedge clk);
        n_vec++; if (bus.hit !== 2'b00) begin n_err++; $display("FAIL held_hit: got %0h expected 0", bus.hit); end
        n_vec++; if (bus.miss_pulse !== 1'b1) begin n_err++; $display("FAIL held_miss: got %0h expected 1", bus.miss_pulse); end
        n_vec++; if (bus.combo !== 8'd0) begin n_err++; $display("FAIL held_combo: got %0d expected 0", bus.combo); end
        bus.btn_raw = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_preempt();
        @(negedge clk);
        bus.note_arrive = 1'b1;
        bus.note_lane   = 2'b01;
        @(negedge clk);
        bus.note_arrive = 1'b0;
        bus.note_lane   = 2'b00;
        @(negedge clk);
        bus.btn_raw = 2'b10;
        @(negedge clk);
        @(negedge clk);
        bus.note_arrive = 1'b1;
        bus.note_lane   = 2'b10;
        @(negedge clk);
        bus.note_arrive = 1'b0;
        bus.note_lane   = 2'b00;
        bus.btn_raw     = 2'b00;
        n_vec++; if (bus.hit !== 2'b00) begin n_err++; $display("FAIL preA_hit: got %0h expected 0", bus.hit); end
        n_vec++; if (bus.hit_valid !== 1'b1) begin n_err++; $display("FAIL preA_hv: got %0h expected 1", bus.hit_valid); end
        n_vec++; if (bus.miss_pulse !== 1'b1) begin n_err++; $display("FAIL preA_miss: got %0h expected 1", bus.miss_pulse); end
        n_vec++; if (bus.combo !== 8'd0) begin n_err++; $display("FAIL preA_combo: got %0d expected 0", bus.combo); end
        repeat (WIN - 1) @(negedge clk);
        n_vec++; if (bus.hit_valid !== 1'b0) begin n_err++; $display("FAIL preB_early_hv: got %0h expected 0", bus.hit_valid); end
        @(negedge clk);
        n_vec++; if (bus.hit !== 2'b10) begin n_err++; $display("FAIL preB_hit: got %0h expected 2", bus.hit); end
        n_vec++; if (bus.hit_valid !== 1'b1) begin n_err++; $display("FAIL preB_hv: got %0h expected 1", bus.hit_valid); end
        n_vec++; if (bus.combo !== 8'd1) begin n_err++; $display("FAIL preB_combo: got %0d expected 1", bus.combo); end
        n_vec++; if (bus.miss_pulse !== 1'b0) begin n_err++; $display("FAIL preB_miss: got %0h expected 0", bus.miss_pulse); end
    endtask

    task automatic test_saturation();
        int exp_c;
        exp_c = 1;
        for (int k = 1; k <= 260; k++) begin
            run_note(2'b01, 2'b01, 1);
            @(negedge clk);
            exp_c = (exp_c < 255) ? exp_c + 1 : 255;
            n_vec++; if (bus.hit_valid !== 1'b1) begin n_err++; $display("FAIL sat_hv[%0d]: got %0h expected 1", k, bus.hit_valid); end
            n_vec++; if (bus.combo !== 8'(exp_c)) begin n_err++; $display("FAIL sat_combo[%0d]: got %0d expected %0d", k, bus.combo, exp_c); end
        end
        n_vec++; if (bus.max_combo !== 8'd255) begin n_err++; $display("FAIL sat_max: got %0d expected 255", bus.max_combo); end
    endtask

    task automatic test_state_abort();
        bit seen;
        @(negedge clk);
        bus.note_arrive = 1'b1;
        bus.note_lane   = 2'b01;
        @(negedge clk);
        bus.note_arrive = 1'b0;
        bus.note_lane   = 2'b00;
        repeat (2) @(negedge clk);
        bus.game_state = 2'd3;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.hit_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_pulse: got %0h expected 0", seen); end
        n_vec++; if (bus.combo !== 8'd255) begin n_err++; $display("FAIL abort_combo_hold: got %0d expected 255", bus.combo); end
        n_vec++; if (bus.max_combo !== 8'd255) begin n_err++; $display("FAIL abort_max_hold: got %0d expected 255", bus.max_combo); end
        bus.game_state = 2'd1;
        @(negedge clk);
        n_vec++; if (bus.combo !== 8'd0) begin n_err++; $display("FAIL select_combo: got %0d expected 0", bus.combo); end
        n_vec++; if (bus.max_combo !== 8'd0) begin n_err++; $display("FAIL select_max: got %0d expected 0", bus.max_combo); end
    endtask

    task automatic test_ignored_and_close_race();
        bit seen;
        bus.game_state = 2'd2;
        @(negedge clk);
        bus.note_arrive = 1'b1;
        bus.note_lane   = 2'b00;
        @(negedge clk);
        bus.note_arrive = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.hit_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL lane0_no_pulse: got %0h expected 0", seen); end
        // State leaves play on the very edge the window would close.
        run_note(2'b01, 2'b01, 1);
        bus.game_state = 2'd3;
        @(negedge clk);
        n_vec++; if (bus.hit_valid !== 1'b0) begin n_err++; $display("FAIL race_hv: got %0h expected 0", bus.hit_valid); end
        n_vec++; if (bus.combo !== 8'd0) begin n_err++; $display("FAIL race_combo: got %0d expected 0", bus.combo); end
    endtask

    initial begin
        bus.game_state  = 2'd0;
        bus.btn_raw     = 2'b00;
        bus.note_arrive = 1'b0;
        bus.note_lane   = 2'b00;
        test_reset();
        test_single_hit();
        test_reset_midwindow();
        test_partial();
        test_close_edge_press();
        test_held_button();
        test_preempt();
        test_saturation();
        test_state_abort();
        test_ignored_and_close_race();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Upstream stage of the score counter in the rhythm-game datapath.
- Synchronises the two player buttons and opens a timing window whenever the note sequencer reports notes reaching the hit line.
- Grades each window into a per-lane hit mask and a running combo.
- Its hit and combo outputs drive the score counter's Inp and combo inputs directly.

Parameters:
WINDOW_CYCLES, 2500000, window length in clk cycles (50 ms at 50 MHz); benches override to 8
CNT_W, 22, window counter width; must satisfy 2^CNT_W > WINDOW_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous assert, active-low
game_state  in  2  0 IDLE, 1 SONG_SELECT, 2 GAME_PLAY, 3 GAME_OVER
btn_raw  in  2  raw lane buttons, asynchronous, bit0 = lane 0
note_arrive  in  1  one-cycle strobe from note sequencer
note_lane  in  2  lanes holding a note at the hit line; valid with note_arrive
hit  out  2  per-lane hit mask; nonzero only in the hit_valid cycle
hit_valid  out  1  one-cycle pulse when a window closes
combo  out  8  consecutive fully-hit windows, saturating at 255
max_combo  out  8  highest combo since the last clear
miss_pulse  out  1  one-cycle pulse when a window closes with any pending lane unhit

Behaviour:
- Reset (rst_n low, asynchronous): hit=0, hit_valid=0, combo=0, max_combo=0, miss_pulse=0. Window closed, synchronisers and edge registers cleared. Reset mid-window discards the window with no output pulse.
- Button input path: per lane, 2-FF synchroniser followed by a previous-value register. press[i] = sync2[i] & ~prev[i]. A raw rise held stable is seen as press 2 cycles after capture and lasts 1 cycle. A held button gives exactly one press.
- Window state: open flag, pending[1:0], got[1:0], cnt[CNT_W-1:0].
- Opening a window: note_arrive=1 with note_lane!=0 in GAME_PLAY at an edge sets:
  - open=1
  - pending=note_lane
  - got=press&note_lane (a press in the arrival cycle counts)
  - cnt=WINDOW_CYCLES-1
- note_arrive with note_lane=0 is ignored.
- While open, each edge:
  - got |= press & pending.
  - Presses on non-pending lanes are ignored.
  - Repeat presses on an already-hit lane are ignored.
  - cnt decrements.
- Natural close: at the edge where open=1 and cnt=0:
  - g = got | (press & pending)
  - hit<=g, hit_valid<=1, open<=0
  - If g==pending: combo<=min(combo+1,255), miss_pulse<=0
  - Else: combo<=0, miss_pulse<=1
  - Window length is exactly WINDOW_CYCLES cycles after the arrival edge; hit_valid rises on edge WINDOW_CYCLES after arrival.
- Preempted close: note_arrive (lane!=0) while open, including at cnt=0.
  - Old window closes in that edge using got only; presses in that cycle credit the new window only.
  - The new window opens in the same edge.
- combo and hit update on the same edge, so the scorer sees the post-update combo together with hit.
- max_combo <= max(max_combo, combo_next) on every edge.
- hit, hit_valid and miss_pulse return to 0 on the edge after their pulse.
- game_state != GAME_PLAY:
  - Any open window is discarded without a pulse; no new window opens.
  - IDLE or SONG_SELECT: combo and max_combo clear to 0 every cycle.
  - GAME_OVER: combo and max_combo hold for display.
- A game_state change and a window close in the same edge: non-play wins, and no pulse is emitted.

Test Plan:
- Reset and idle (WINDOW_CYCLES=8): assert rst_n low mid-window, release → all outputs 0, no hit_valid for 20 cycles.
- Single-lane hit: note_arrive, lane=01 at edge E; btn_raw[0] rises 3 cycles later → at edge E+8: hit=01, hit_valid=1, combo 0→1, miss_pulse=0.
- Double-note partial: lane=11, only btn 1 pressed → hit=10, combo→0, miss_pulse=1; max_combo keeps its prior value.
- Combo saturation: 260 consecutive full-hit single notes → combo increments to 255 and holds; max_combo=255.
- Preemption with simultaneous press: window A (lane 01) open and unhit; note_arrive lane 10 in the same cycle as a lane-1 press → A closes with hit=00, miss_pulse=1; B opens with got=10 and closes with hit=10, combo=1.
- State abort: game_state goes 2→3 mid-window → no hit_valid, combo held. Then 3→1 → combo=0 and max_combo=0 the next cycle.
